// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the single-port byte-lane data memory.
// Round-robin with a bounded lock; routes one-cycle-latency read data to its issuer.
module dm_port_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic [DATA_W/8-1:0]   m0_we,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic                  m0_lock,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,

    input  logic                  m1_req,
    input  logic [DATA_W/8-1:0]   m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,

    output logic                  mem_cs,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  owner,
    output logic                  locked
);

    localparam int BE_W = DATA_W / 8;
    localparam int HC_W = $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);

    logic            rr_last;
    logic [HC_W-1:0] hold_cnt;
    logic            rd_pending;
    logic            rd_id;

    logic            owner_req;
    logic            other_req;
    logic            g0;
    logic            g1;
    logic            lock_break;
    logic            accept;
    logic            win;
    logic            win_lock;
    logic [BE_W-1:0] win_we;

    always_comb begin
        owner_req  = owner ? m1_req : m0_req;
        other_req  = owner ? m0_req : m1_req;
        g0         = 1'b0;
        g1         = 1'b0;
        lock_break = 1'b0;
        if (!rst) begin
            g0 = 1'b0;
            g1 = 1'b0;
        end else if (locked && owner_req && (hold_cnt < HOLD_MAX)) begin
            g0 = ~owner;
            g1 = owner;
        end else if (locked && (hold_cnt == HOLD_MAX) && other_req) begin
            // Owner has used up its burst: hand one grant to the waiting side.
            g0         = owner;
            g1         = ~owner;
            lock_break = 1'b1;
        end else if (m0_req && !m1_req) begin
            g0 = 1'b1;
        end else if (m1_req && !m0_req) begin
            g1 = 1'b1;
        end else if (m0_req && m1_req) begin
            g0 = rr_last;
            g1 = ~rr_last;
        end
    end

    assign accept   = g0 | g1;
    assign win      = g1;
    assign win_lock = win ? m1_lock : m0_lock;
    assign win_we   = win ? m1_we : m0_we;

    assign m0_gnt    = g0;
    assign m1_gnt    = g1;
    assign mem_cs    = accept;
    assign mem_we    = accept ? win_we : '0;
    assign mem_addr  = win ? m1_addr : m0_addr;
    assign mem_wdata = win ? m1_wdata : m0_wdata;

    // Read data is shared; only the issuer sees rvalid. Reset masks a pending return.
    assign m0_rvalid = rst & rd_pending & ~rd_id;
    assign m1_rvalid = rst & rd_pending & rd_id;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_last    <= 1'b1;
            locked     <= 1'b0;
            owner      <= 1'b0;
            hold_cnt   <= '0;
            rd_pending <= 1'b0;
            rd_id      <= 1'b0;
        end else begin
            if (accept) begin
                rr_last <= win;
            end

            if (accept && (win_we == '0)) begin
                rd_pending <= 1'b1;
                rd_id      <= win;
            end else begin
                rd_pending <= 1'b0;
            end

            if (locked && (!owner_req || lock_break)) begin
                locked   <= 1'b0;
                hold_cnt <= '0;
            end else if (accept) begin
                if (win_lock) begin
                    locked <= 1'b1;
                    owner  <= win;
                    if (locked && (owner == win)) begin
                        hold_cnt <= (hold_cnt < HOLD_MAX) ? hold_cnt + 1'b1 : HOLD_MAX;
                    end else begin
                        hold_cnt <= HC_W'(1);
                    end
                end else begin
                    locked   <= 1'b0;
                    hold_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: table vectors, directed corner sequences and a
// randomized run, all checked against a spec-level model with its own memory image.
module tb_dm_port_arbiter;

    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [3:0]  m0_we, m1_we;
    logic [13:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_cs;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        owner, locked;

    always #5 clk = ~clk;

    dm_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .locked(locked)
    );

    // Physical single-port memory seen by the DUT.
    logic [31:0] phys [DEPTH];
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we == 4'h0) mem_rdata <= phys[mem_addr];
            else for (int b = 0; b < 4; b++)
                if (mem_we[b]) phys[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model state, expressed directly from the arbitration rules.
    logic [31:0] ref_mem [DEPTH];
    int  r_rr, r_owner, r_hold, r_pend;
    bit  r_locked, r_brk;
    logic [31:0] r_pdata;
    int  r_win;

    task automatic model_reset();
        r_rr = 1; r_owner = 0; r_hold = 0; r_locked = 0; r_pend = -1;
    endtask

    task automatic model_check();
        bit req [2];
        logic [3:0]  we [2];
        logic [13:0] ad [2];
        logic [31:0] wd [2];
        req[0] = m0_req; req[1] = m1_req;
        we[0] = m0_we;   we[1] = m1_we;
        ad[0] = m0_addr; ad[1] = m1_addr;
        wd[0] = m0_wdata; wd[1] = m1_wdata;
        r_win = -1; r_brk = 0;
        if (!rst) r_win = -1;
        else if (r_locked && req[r_owner] && r_hold < MAX_HOLD) r_win = r_owner;
        else if (r_locked && r_hold == MAX_HOLD && req[1-r_owner]) begin
            r_win = 1 - r_owner; r_brk = 1;
        end
        else if (req[0] != req[1]) r_win = req[0] ? 0 : 1;
        else if (req[0] && req[1]) r_win = 1 - r_rr;

        chk("gnt0", 32'(m0_gnt), 32'(r_win == 0));
        chk("gnt1", 32'(m1_gnt), 32'(r_win == 1));
        chk("mem_cs", 32'(mem_cs), 32'(r_win >= 0));
        chk("rvalid0", 32'(m0_rvalid), 32'(rst && r_pend == 0));
        chk("rvalid1", 32'(m1_rvalid), 32'(rst && r_pend == 1));
        if (rst && r_pend == 0) chk("rdata0", m0_rdata, r_pdata);
        if (rst && r_pend == 1) chk("rdata1", m1_rdata, r_pdata);
        chk("locked", 32'(locked), 32'(r_locked));
        if (r_locked) chk("owner", 32'(owner), 32'(r_owner));
        if (r_win >= 0) begin
            chk("mem_addr", 32'(mem_addr), 32'(ad[r_win]));
            chk("mem_we", 32'(mem_we), 32'(we[r_win]));
            if (we[r_win] != 4'h0) chk("mem_wdata", mem_wdata, wd[r_win]);
        end else begin
            chk("mem_we_idle", 32'(mem_we), 32'h0);
        end
    endtask

    task automatic model_update();
        bit req [2];
        bit lk [2];
        logic [3:0]  we [2];
        logic [13:0] ad [2];
        logic [31:0] wd [2];
        req[0] = m0_req; req[1] = m1_req;
        lk[0] = m0_lock; lk[1] = m1_lock;
        we[0] = m0_we;   we[1] = m1_we;
        ad[0] = m0_addr; ad[1] = m1_addr;
        wd[0] = m0_wdata; wd[1] = m1_wdata;
        if (!rst) begin
            model_reset();
            return;
        end
        r_pend = -1;
        if (r_win >= 0) begin
            r_rr = r_win;
            if (we[r_win] == 4'h0) begin
                r_pend  = r_win;
                r_pdata = ref_mem[ad[r_win]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (we[r_win][b]) ref_mem[ad[r_win]][8*b +: 8] = wd[r_win][8*b +: 8];
            end
        end
        if (r_locked && (!req[r_owner] || r_brk)) begin
            r_locked = 0; r_hold = 0;
        end else if (r_win >= 0) begin
            if (lk[r_win]) begin
                r_hold   = (r_locked && r_owner == r_win) ?
                           ((r_hold + 1 > MAX_HOLD) ? MAX_HOLD : r_hold + 1) : 1;
                r_locked = 1;
                r_owner  = r_win;
            end else begin
                r_locked = 0; r_hold = 0;
            end
        end
    endtask

    // Inputs are set in the low phase; check, then let the edge happen.
    task automatic tick();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_lock = 0; m0_we = 4'h0; m0_addr = 14'h2000; m0_wdata = 32'h0;
        m1_req = 0; m1_lock = 0; m1_we = 4'h0; m1_addr = 14'h3fff; m1_wdata = 32'h0;
    endtask

    typedef struct {
        logic rst, r0, r1, l1;
        logic e_g0, e_g1, e_lk;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic rs, input logic r0, input logic r1, input logic l1,
                       input logic g0, input logic g1, input logic lk);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.r1 = r1; v.l1 = l1;
        v.e_g0 = g0; v.e_g1 = g1; v.e_lk = lk;
        vecs.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            phys[i]    = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
            ref_mem[i] = (i * 32'h9E3779B1) ^ 32'h5A5A0000;
        end
        rst = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);

        // reset with both requesting, release, round-robin
        add(0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 0, 1, 0, 0);
        add(1, 1, 1, 0, 0, 1, 0);
        add(1, 1, 1, 0, 1, 0, 0);
        add(1, 1, 1, 0, 0, 1, 0);
        // m1 locks; m0 joins on the third locked cycle
        add(1, 0, 1, 1, 0, 1, 0);
        add(1, 0, 1, 1, 0, 1, 1);
        add(1, 1, 1, 1, 0, 1, 1);
        add(1, 1, 1, 1, 0, 1, 1);
        add(1, 1, 1, 1, 1, 0, 1);
        add(1, 1, 1, 1, 0, 1, 0);
        add(1, 1, 1, 1, 0, 1, 1);
        add(1, 1, 1, 1, 0, 1, 1);
        add(1, 1, 1, 1, 0, 1, 1);
        add(1, 1, 1, 1, 1, 0, 1);
        // lone locked owner is never throttled
        add(1, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 9; i++) add(1, 0, 1, 1, 0, 1, 1);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; m0_req = vecs[i].r0; m1_req = vecs[i].r1; m1_lock = vecs[i].l1;
            #1;
            chk($sformatf("vec%0d_gnt0", i), 32'(m0_gnt), 32'(vecs[i].e_g0));
            chk($sformatf("vec%0d_gnt1", i), 32'(m1_gnt), 32'(vecs[i].e_g1));
            chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(vecs[i].e_lk));
            tick();
        end

        // write then read back at the top word, then a byte-lane merge
        idle_inputs();
        m1_req = 1; m1_we = 4'hF; m1_addr = 14'h3fff; m1_wdata = 32'hFFFFFFFF;
        tick();
        m1_we = 4'h0;
        tick();
        m1_req = 0;
        #1;
        chk("raw_rvalid", 32'(m1_rvalid), 32'h1);
        chk("raw_rdata", m1_rdata, 32'hFFFFFFFF);
        tick();
        m1_req = 1; m1_we = 4'hF; m1_addr = 14'h0100; m1_wdata = 32'h12345678;
        tick();
        m1_we = 4'h1; m1_wdata = 32'h000000AB;
        tick();
        m1_we = 4'h0;
        tick();
        m1_req = 0;
        #1;
        chk("byte_rvalid", 32'(m1_rvalid), 32'h1);
        chk("byte_rdata", m1_rdata, 32'h123456AB);
        tick();

        // reset while a read is in flight
        m0_req = 1; m0_addr = 14'h2000;
        tick();
        rst = 0; m1_req = 1;
        #1;
        chk("rstmid_rvalid0", 32'(m0_rvalid), 32'h0);
        chk("rstmid_gnt0", 32'(m0_gnt), 32'h0);
        tick();
        #1;
        chk("rstmid_rvalid0_after", 32'(m0_rvalid), 32'h0);
        chk("rstmid_locked", 32'(locked), 32'h0);
        tick();
        rst = 1;
        #1;
        chk("rstmid_first_gnt0", 32'(m0_gnt), 32'h1);
        chk("rstmid_first_gnt1", 32'(m1_gnt), 32'h0);
        tick();

        // randomized traffic, including occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 63) != 0);
            m0_req   = $urandom_range(0, 3) != 0;
            m1_req   = $urandom_range(0, 3) != 0;
            m0_lock  = $urandom_range(0, 1);
            m1_lock  = $urandom_range(0, 2) != 0;
            m0_we    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            m1_we    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            m0_addr  = $urandom_range(0, 1) ? 14'h3fff : 14'($urandom_range(0, 7));
            m1_addr  = $urandom_range(0, 1) ? 14'h3fff : 14'($urandom_range(0, 7));
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
Shares the single-port, byte-lane data memory between two requesters. m0 is the CPU load/store port; m1 is a debug/loader master used for preloading memory, checking results and polling the SIM_END word at word 0x3fff.
The block runs round-robin arbitration with an optional bounded lock for back-to-back sequences. It issues one memory command per cycle and routes the one-cycle-latency read data back to the requester that issued the read.

Parameters:
ADDR_W, 14, word-address width (16K words; covers SIM_END word 0x3fff)
DATA_W, 32, data width; byte enables are DATA_W/8 bits wide
MAX_HOLD, 4, maximum consecutive locked grants to one requester while the other is requesting

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous active-low reset; rst=0 at a rising edge resets all state
m0_req  in  1  CPU request valid
m0_we  in  4  CPU byte write enables; 0 means read
m0_addr  in  ADDR_W  CPU word address
m0_wdata  in  DATA_W  CPU write data
m0_lock  in  1  CPU requests priority on its next request
m0_gnt  out  1  CPU request accepted this cycle
m0_rvalid  out  1  CPU read data valid
m0_rdata  out  DATA_W  CPU read data
m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata: same as the m0 signals, for the debug/loader master
mem_cs  out  1  memory command strobe
mem_we  out  4  memory byte write enables
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after a read command
owner  out  1  requester holding the lock (0=m0, 1=m1); meaningful only while locked=1
locked  out  1  lock currently active

Behaviour:
- Reset (rst=0): outputs m*_gnt=0, m*_rvalid=0, mem_cs=0, locked=0, owner=0. Internal state: rr_last=1 (m0 wins the first tie), hold_cnt=0, rd_pending=0. While rst=0, gnt is forced to 0 regardless of req.
- Grant is combinational from this cycle's req and registered state. At most one gnt per cycle. A request is accepted when req & gnt.
- Arbitration priority, highest first:
  1. If locked=1 and the owner is requesting and hold_cnt<MAX_HOLD: grant the owner.
  2. If locked=1 and hold_cnt==MAX_HOLD and the other requester is requesting: grant the other requester. The lock is broken.
  3. Otherwise, if only one requester is requesting: grant it.
  4. Otherwise, if both are requesting: grant the requester that is not rr_last.
- On an accepted request: mem_cs=1 and mem_we/mem_addr/mem_wdata are driven from the winner in the same cycle. With no acceptance: mem_cs=0 and mem_we=0.
- rr_last updates to the winner on each accepted request. It holds when nothing is accepted.
- Lock state, updated on each accepted request:
  - If the winner's lock=1: locked<=1, owner<=winner, and hold_cnt<=(winner==owner && locked) ? hold_cnt+1 : 1.
  - If the winner's lock=0: locked<=0, hold_cnt<=0.
- Lock release: if locked=1 and the owner is not requesting in a cycle, locked<=0 and hold_cnt<=0, even if the other requester is granted in that cycle. Case 2 clears the lock.
- A lone owner is never throttled. If the other requester is idle, the owner is granted even when hold_cnt==MAX_HOLD; hold_cnt saturates at MAX_HOLD.
- Read return: an accepted read (we==0) sets rd_pending<=1 and rd_id<=winner. The next cycle, m[rd_id]_rvalid=1 and m[rd_id]_rdata=mem_rdata. The other requester's rdata is undefined and its rvalid=0. Writes never produce rvalid.
- Back-to-back reads from alternating requesters are legal: rd_pending/rd_id are overwritten every cycle, giving one rvalid per read with no gaps.
- Read-after-write to the same address in consecutive cycles returns the new data. Memory ordering is preserved because commands issue in grant order.
- Reset mid-operation: a pending rvalid is dropped (0 in the reset cycle and the cycle after). The lock is cleared.
- Width: addresses pass through unmodified. No wrap logic; address 2^ADDR_W-1 is a legal target.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with m0_req=m1_req=1 -> gnt=0, mem_cs=0, rvalid=0. Release -> first cycle grants m0 (rr_last=1).
2. Round-robin: both request reads continuously, m0_addr=0x2000, m1_addr=0x3fff -> grants alternate m0,m1,m0,m1. Each rvalid appears exactly one cycle after its grant with the matching word.
3. Lock fairness: m1_lock=1 and m1_req=1 continuously, m0_req=1 from cycle 2 -> m1 gets 4 consecutive grants, then m0 gets 1. locked=0 after the break. m1 relocks on its next grant.
4. Lone owner: m1_lock=1 and m1_req=1 for 10 cycles, m0_req=0 -> 10 consecutive m1 grants, hold_cnt saturates at 4, no stalls.
5. Write then read: m1 writes 0xFFFFFFFF to 0x3fff with we=4'hF, then reads 0x3fff next cycle -> m1_rvalid with 0xFFFFFFFF. A byte write with we=4'h1 and data 0x000000AB over 0x12345678 reads back 0x123456AB.
6. Reset mid-read: m0 read is accepted, rst=0 on the next edge -> m0_rvalid=0. After release, the state is identical to scenario 1.
